// File: rtl/stream_proc_pkg.sv
// Shared constants and helpers for the stateful stream processor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_proc_pkg;

    localparam int MODE_PER_BEAT   = 0;
    localparam int MODE_PER_PACKET = 1;

    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Result entries are packed {last, data[OUT_WIDTH-1:0]}; last is the MSB.
    function automatic int result_entry_width(input int out_width);
        return out_width + 1;
    endfunction

endpackage

// File: rtl/stream_result_fifo.sv
// Show-ahead synchronous FIFO holding packed result entries.
// Latency: push visible at the head one cycle later; head is valid combinationally.
// Backpressure: pop only when non-empty; pushes are expected never to hit a full FIFO.
module stream_result_fifo
    import stream_proc_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push_vld,
    input  logic [WIDTH-1:0]                push_dat,
    input  logic                            pop_rdy,
    output logic                            pop_vld,
    output logic [WIDTH-1:0]                pop_dat,
    output logic [ceil_log2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = ceil_log2(DEPTH);
    localparam int CNT_W = ceil_log2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_vld = !empty;
    // Head is forced to zero when empty so the outputs are clean out of reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stateful_stream_processor.sv
// Feeds beats to an external engine and queues per-beat or per-packet results.
// Latency: ENGINE_LATENCY+1 cycles from accepted beat to out_valid on an empty FIFO.
// Backpressure: in_ready only while FIFO occupancy plus in-flight tags leaves a free slot.
module stateful_stream_processor
    import stream_proc_pkg::*;
#(
    parameter int REPLICATION_FACTOR = 3,
    parameter int OUT_WIDTH          = 8,
    parameter int FIFO_DEPTH         = 16,
    parameter int ENGINE_LATENCY     = 2,
    parameter int MODE               = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [8*REPLICATION_FACTOR-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            eng_enable,
    output logic [8*REPLICATION_FACTOR-1:0] eng_value,
    output logic                            eng_last,
    input  logic                            eng_o_value,
    input  logic                            eng_o_valid,
    output logic                            protocol_error
);

    localparam int EW    = result_entry_width(OUT_WIDTH);
    localparam int CNT_W = ceil_log2(FIFO_DEPTH + 1);
    localparam int IF_W  = ceil_log2(ENGINE_LATENCY + 1);
    localparam int SUM_W = ceil_log2(FIFO_DEPTH + ENGINE_LATENCY + 1);

    typedef struct packed {
        logic                 last;
        logic [OUT_WIDTH-1:0] data;
    } result_t;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    tag_t [ENGINE_LATENCY-1:0] tag_pipe;
    tag_t                      emerge;
    logic                      ready_en;
    logic                      accept;
    logic [IF_W-1:0]           inflight;
    logic [CNT_W-1:0]          fifo_count;
    logic                      res_bit;
    logic [OUT_WIDTH-1:0]      acc;
    logic [OUT_WIDTH-1:0]      acc_sum;
    logic                      push_vld;
    result_t                   push_entry;
    result_t                   head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ENGINE_LATENCY; i++) begin
            inflight = inflight + IF_W'(tag_pipe[i].vld);
        end
    end

    // ready_en holds in_ready low for the first cycle after reset release.
    assign in_ready   = ready_en && enable &&
                        ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
    assign accept     = in_valid && in_ready;
    assign eng_enable = accept;
    assign eng_value  = in_data;
    assign eng_last   = in_last;

    assign emerge  = tag_pipe[ENGINE_LATENCY-1];
    assign res_bit = eng_o_valid && eng_o_value;
    assign acc_sum = (acc == '1) ? acc : acc + OUT_WIDTH'(res_bit);

    always_comb begin
        push_vld   = 1'b0;
        push_entry = '0;
        if (emerge.vld) begin
            if (MODE == MODE_PER_BEAT) begin
                push_vld        = 1'b1;
                push_entry.last = emerge.last;
                push_entry.data = OUT_WIDTH'(res_bit);
            end else if (emerge.last) begin
                push_vld        = 1'b1;
                push_entry.last = 1'b1;
                push_entry.data = acc_sum;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en       <= 1'b0;
            tag_pipe       <= '0;
            acc            <= '0;
            protocol_error <= 1'b0;
        end else begin
            ready_en        <= 1'b1;
            tag_pipe[0].vld <= accept;
            tag_pipe[0].last <= accept && in_last;
            for (int i = 1; i < ENGINE_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (emerge.vld && (MODE == MODE_PER_PACKET)) begin
                acc <= emerge.last ? '0 : acc_sum;
            end
            // A tag without an engine result, or a result without a tag, is a latency violation.
            if (emerge.vld != eng_o_valid) protocol_error <= 1'b1;
        end
    end

    stream_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_entry),
        .pop_rdy  (out_ready),
        .pop_vld  (out_valid),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    assign out_data = head.data;
    assign out_last = head.last;

endmodule

// File: tb/tb_stateful_stream_processor.sv
// Directed bench for stateful_stream_processor: three instances (per-beat depth 4,
// per-packet 8-bit, per-packet 2-bit) each driven by a small fixed-latency engine model.
module tb_stateful_stream_processor;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  enable, in_valid, in_last, out_ready, drop;
    logic [23:0] in_data [3];
    logic [2:0]  in_ready, out_valid, out_last, eng_enable, eng_last;
    logic [2:0]  eng_o_value, eng_o_valid, perr;
    logic [23:0] eng_value [3];
    logic [7:0]  od0, od1;
    logic [1:0]  od2;
    logic [7:0]  od_all [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int first_acc [3];
    int first_vld [3];
    int acc_m [3];
    logic [8:0] sb0 [$];
    logic [8:0] sb1 [$];
    logic [8:0] sb2 [$];
    logic [8:0] mon_e;
    bit         mon_ok;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign od_all[0] = od0;
    assign od_all[1] = od1;
    assign od_all[2] = {6'b0, od2};

    stateful_stream_processor #(.REPLICATION_FACTOR(3), .OUT_WIDTH(8), .FIFO_DEPTH(4),
                                .ENGINE_LATENCY(2), .MODE(0)) u_beat (
        .clock(clock), .reset(reset), .enable(enable[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_last(in_last[0]),
        .out_data(od0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .eng_enable(eng_enable[0]), .eng_value(eng_value[0]),
        .eng_last(eng_last[0]), .eng_o_value(eng_o_value[0]), .eng_o_valid(eng_o_valid[0]),
        .protocol_error(perr[0]));

    stateful_stream_processor #(.REPLICATION_FACTOR(3), .OUT_WIDTH(8), .FIFO_DEPTH(16),
                                .ENGINE_LATENCY(2), .MODE(1)) u_pkt (
        .clock(clock), .reset(reset), .enable(enable[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_last(in_last[1]),
        .out_data(od1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .eng_enable(eng_enable[1]), .eng_value(eng_value[1]),
        .eng_last(eng_last[1]), .eng_o_value(eng_o_value[1]), .eng_o_valid(eng_o_valid[1]),
        .protocol_error(perr[1]));

    stateful_stream_processor #(.REPLICATION_FACTOR(3), .OUT_WIDTH(2), .FIFO_DEPTH(16),
                                .ENGINE_LATENCY(2), .MODE(1)) u_sat (
        .clock(clock), .reset(reset), .enable(enable[2]), .in_data(in_data[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_last(in_last[2]),
        .out_data(od2), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_last(out_last[2]), .eng_enable(eng_enable[2]), .eng_value(eng_value[2]),
        .eng_last(eng_last[2]), .eng_o_value(eng_o_value[2]), .eng_o_valid(eng_o_valid[2]),
        .protocol_error(perr[2]));

    // Engine model: answers 1 for "abc" exactly two cycles after each strobe; drop suppresses o_valid.
    for (genvar g = 0; g < 3; g++) begin : g_eng
        logic [2:0] p0, p1;
        always @(posedge clock or negedge reset) begin
            if (!reset) begin
                p0 <= 3'b0;
                p1 <= 3'b0;
            end else begin
                p0 <= {eng_enable[g], eng_value[g] == 24'h616263, drop[g]};
                p1 <= p0;
            end
        end
        assign eng_o_valid[g] = p1[2] & ~p1[0];
        assign eng_o_value[g] = p1[2] & p1[1] & ~p1[0];
    end

    function automatic void sb_push(input int i, input logic [8:0] v);
        case (i)
            0:       sb0.push_back(v);
            1:       sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endfunction

    function automatic int sb_size(input int i);
        case (i)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic sb_pop(input int i, output logic [8:0] v, output bit ok);
        ok = (sb_size(i) != 0);
        v  = 9'h1ff;
        if (ok) begin
            case (i)
                0:       v = sb0.pop_front();
                1:       v = sb1.pop_front();
                default: v = sb2.pop_front();
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: instance 0 reports per beat, instances 1 and 2 per packet (sat 255 / 3).
    task automatic model_beat(input int i, input logic [23:0] d, input bit last, input bit drp);
        int r, mx, s;
        r  = (!drp && d == 24'h616263) ? 1 : 0;
        mx = (i == 2) ? 3 : 255;
        if (first_acc[i] < 0) first_acc[i] = cyc;
        if (i == 0) begin
            sb_push(0, {last, 8'(r)});
        end else begin
            s = (acc_m[i] + r > mx) ? mx : acc_m[i] + r;
            if (last) begin
                sb_push(i, {1'b1, 8'(s)});
                acc_m[i] = 0;
            end else begin
                acc_m[i] = s;
            end
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase after the beat is taken.
    task automatic send(input int i, input logic [23:0] d, input bit last, input bit drp);
        int n;
        in_data[i]  = d;
        in_last[i]  = last;
        drop[i]     = drp;
        in_valid[i] = 1'b1;
        #1;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (!in_ready[i]) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: instance %0d in_ready stayed 0", i);
        end else begin
            model_beat(i, d, last, drp);
        end
        @(posedge clock);
        #1;
        in_valid[i] = 1'b0;
        drop[i]     = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && first_vld[i] < 0) first_vld[i] = cyc;
                if (out_valid[i] && out_ready[i]) begin
                    sb_pop(i, mon_e, mon_ok);
                    checks++;
                    assert (mon_ok && ({out_last[i], od_all[i]} === mon_e)) else begin
                        errors++;
                        $error("FAIL out_word[%0d]: observed last=%0b data=%0h expected %0h (queued=%0b)",
                               i, out_last[i], od_all[i], mon_e, mon_ok);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        enable    = 3'b000;
        in_valid  = 3'b000;
        in_last   = 3'b000;
        out_ready = 3'b000;
        drop      = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_data[i]   = '0;
            first_acc[i] = -1;
            first_vld[i] = -1;
            acc_m[i]     = 0;
        end
        #2;
        chk("rst_out_valid", 32'(out_valid[0]), 0);
        chk("rst_out_data", 32'(od0), 0);
        chk("rst_out_last", 32'(out_last[0]), 0);
        chk("rst_perr", 32'(perr[0]), 0);
        enable    = 3'b111;
        out_ready = 3'b111;
        #1;
        chk("rst_in_ready", 32'(in_ready[0]), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_hold", 32'(in_ready[0]), 0);
        @(posedge clock);
        #2;
        chk("rel_in_ready_up", 32'(in_ready[0]), 1);
        wait_cycles(1);

        // Per-beat 3-beat packet
        send(0, 24'h616263, 1'b0, 1'b0);
        send(0, 24'h000000, 1'b0, 1'b0);
        send(0, 24'h616263, 1'b1, 1'b0);
        wait_cycles(6);
        chk("beat_latency", 32'(first_vld[0] - first_acc[0]), 3);

        // Per-packet: same packet then a 2-beat zero packet
        send(1, 24'h616263, 1'b0, 1'b0);
        send(1, 24'h000000, 1'b0, 1'b0);
        send(1, 24'h616263, 1'b1, 1'b0);
        send(1, 24'h000000, 1'b0, 1'b0);
        send(1, 24'h000000, 1'b1, 1'b0);
        wait_cycles(6);

        // 2-bit accumulator saturates at 3
        for (int k = 0; k < 5; k++) send(2, 24'h616263, k == 4, 1'b0);
        wait_cycles(6);

        enable[0] = 1'b0;
        #1;
        chk("enable_low_ready", 32'(in_ready[0]), 0);
        enable[0] = 1'b1;
        #1;
        chk("enable_high_ready", 32'(in_ready[0]), 1);

        // Backpressure with depth 4
        begin
            int n_acc;
            n_acc = 0;
            out_ready[0] = 1'b0;
            wait_cycles(1);
            for (int k = 0; k < 8; k++) begin
                in_data[0]  = (k % 2 == 0) ? 24'h616263 : 24'h000000;
                in_last[0]  = 1'b1;
                in_valid[0] = 1'b1;
                #1;
                if (in_ready[0]) begin
                    model_beat(0, in_data[0], 1'b1, 1'b0);
                    n_acc++;
                end
                @(posedge clock);
                #1;
            end
            in_valid[0] = 1'b0;
            chk("bp_accepts", 32'(n_acc), 4);
            #1;
            chk("bp_full_ready", 32'(in_ready[0]), 0);
            out_ready[0] = 1'b1;
            #1;
            chk("bp_first_pop_ready", 32'(in_ready[0]), 0);
            @(posedge clock);
            #2;
            chk("bp_reassert", 32'(in_ready[0]), 1);
            wait_cycles(8);
        end

        // Engine drops o_valid for one beat
        chk("perr_before", 32'(perr[0]), 0);
        send(0, 24'h616263, 1'b1, 1'b1);
        wait_cycles(4);
        chk("perr_set", 32'(perr[0]), 1);
        wait_cycles(5);
        chk("perr_sticky", 32'(perr[0]), 1);
        chk("perr_other", 32'(perr[2:1]), 0);

        // Reset mid-packet with two results queued
        out_ready[0] = 1'b0;
        send(0, 24'h616263, 1'b0, 1'b0);
        send(0, 24'h000000, 1'b0, 1'b0);
        wait_cycles(5);
        chk("t6_queued", 32'(out_valid[0]), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid[0]), 0);
        chk("t6_rst_perr", 32'(perr[0]), 0);
        chk("t6_rst_ready", 32'(in_ready[0]), 0);
        sb0.delete();
        sb1.delete();
        sb2.delete();
        for (int i = 0; i < 3; i++) acc_m[i] = 0;
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(1);
        out_ready[0] = 1'b1;
        send(0, 24'h616263, 1'b1, 1'b0);
        wait_cycles(6);
        chk("t6_perr_clean", 32'(perr[0]), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("sb_empty_%0d", i), 32'(sb_size(i)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
